braille_session_ctrl: RTL and testbench
=======================================

Name: braille_session_ctrl

Overview:
- Sequences one training session of the Braille trainer: steps through NUM_CHARS characters, shows each dot pattern for a fixed time, opens a timed answer window, then grades the learner's entered pattern and shows feedback.
- Sits between the 1 s tick generator (timeout1s source) and the character ROM, display driver and score display.
- All dwell times are counted in whole timeout1s ticks.

Parameters:
- SHOW_SECS, 2, dwell in SHOW, in ticks (legal range 1..15)
- ANSWER_SECS, 5, length of the answer window, in ticks (1..15)
- FB_SECS, 1, dwell in FEEDBACK, in ticks (1..15)
- NUM_CHARS, 26, characters per session (1..32)
- SCORE_W, 6, width of the score counter

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- timeout1s  in  1  one-clk-wide 1 s tick
- start  in  1  session start request, sampled each clk
- submit  in  1  one-clk learner "enter" pulse
- dots_in  in  6  learner dot pattern; bit i = dot i+1
- char_pattern  in  6  ROM pattern for char_idx, valid combinationally
- char_idx  out  5  index of the current character
- show_en  out  1  display the target pattern
- prompt  out  1  answer window open
- correct  out  1  high throughout FEEDBACK when the answer matched
- wrong  out  1  high throughout FEEDBACK on mismatch or timeout
- score  out  SCORE_W  count of correct answers, saturating
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high. All outputs are registered.
- Reset values: state IDLE; char_idx=0; score=0; every 1-bit output 0; tick counter 0.
- States: IDLE, SHOW, ANSWER, FEEDBACK, DONE.
- Tick counter:
  - Cleared on every state entry.
  - Increments on each timeout1s tick.
  - The state "expires" on the cycle a tick arrives while count == N-1, i.e. on the Nth tick after entry.
  - Because of the partial first second, the real dwell lies between N-1 and N seconds. This is accepted.
- IDLE:
  - start=1 → SHOW next cycle, with char_idx=0, score=0, busy=1.
- SHOW:
  - show_en=1.
  - Expiry after SHOW_SECS → ANSWER.
  - submit is ignored in this state.
- ANSWER:
  - prompt=1, show_en=0.
  - On submit: latch (dots_in == char_pattern).
    - Match: correct=1, and score increments, saturating at 2^SCORE_W-1.
    - Mismatch: wrong=1.
    - Either way → FEEDBACK.
  - Expiry after ANSWER_SECS with no submit → wrong=1 → FEEDBACK.
  - submit and an expiring tick in the same cycle: submit wins and is graded.
- FEEDBACK:
  - correct/wrong hold their value for the whole state; prompt=0.
  - On expiry after FB_SECS:
    - If char_idx == NUM_CHARS-1 → DONE.
    - Otherwise char_idx+1 → SHOW.
  - correct/wrong clear on exit.
- DONE:
  - done=1, busy=0.
  - score and char_idx hold their final values.
  - start=1 → SHOW, with char_idx=0 and score=0 (new session).
- start while busy is ignored.
- submit outside ANSWER is ignored.
- Multiple submits: only the first one in ANSWER counts, since the state leaves on that cycle.
- An asynchronous rst mid-session returns to the reset values immediately, including score.
- correct and wrong are mutually exclusive at all times.

Decomposition:
- Package braille_pkg holds:
  - the state enum
  - DOT_W=6
  - IDX_W=5
  - helper constant MAX_CHARS=32
- One natural sub-module: sec_dwell_timer.
  - Inputs: clk, rst, clear, timeout1s, limit[3:0].
  - Output: expire pulse.
  - Contains the tick counter.
- The FSM, score and index logic stay in braille_session_ctrl.

Test Plan:
1. Defaults, tick every 10 clks: pulse start → SHOW for 2 ticks → ANSWER. Submit dots_in=6'b000001 with char_pattern=6'b000001 → correct=1 for 1 tick, score=1, char_idx=1, back in SHOW.
2. ANSWER with no submit for 5 ticks → wrong=1, score unchanged, FEEDBACK lasts 1 tick, char_idx advances.
3. NUM_CHARS=3, all answers correct → DONE with done=1, score=3, char_idx=2. Then start → SHOW with score=0, char_idx=0.
4. submit coinciding with the 5th (expiring) ANSWER tick, patterns matching → correct=1 (not wrong), score increments.
5. SCORE_W=2, NUM_CHARS=5, all correct → score saturates at 3. Also: submit during SHOW and FEEDBACK, and start while busy, are all ignored.
6. Assert rst asynchronously (mid-clk) during ANSWER with score=2 → all outputs 0 and state IDLE before the next clk edge. After release, the next start begins a fresh session.

Source files
------------

// File: rtl/braille_pkg.sv
// braille_pkg: shared widths, limits and FSM state encoding for the Braille session controller.
package braille_pkg;
  localparam int DOT_W     = 6;
  localparam int IDX_W     = 5;
  localparam int MAX_CHARS = 32;
  typedef enum logic [2:0] {ST_IDLE, ST_SHOW, ST_ANSWER, ST_FEEDBACK, ST_DONE} state_t;
endpackage

// File: rtl/sec_dwell_timer.sv
// sec_dwell_timer: counts 1 s ticks since the last clear and pulses expire on the limit-th tick.
module sec_dwell_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       timeout1s,
  input  logic [3:0] limit,
  output logic       expire
);
  logic [3:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (clear) r_cnt <= '0;
    else if (timeout1s) r_cnt <= r_cnt + 4'd1;
  assign expire = timeout1s && (r_cnt == limit - 4'd1);
endmodule

// File: rtl/braille_session_ctrl.sv
// braille_session_ctrl: sequences show / answer / feedback per character and keeps a saturating score.
module braille_session_ctrl
  import braille_pkg::*;
#(
  parameter int SHOW_SECS   = 2,
  parameter int ANSWER_SECS = 5,
  parameter int FB_SECS     = 1,
  parameter int NUM_CHARS   = 26,
  parameter int SCORE_W     = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               timeout1s,
  input  logic               start,
  input  logic               submit,
  input  logic [DOT_W-1:0]   dots_in,
  input  logic [DOT_W-1:0]   char_pattern,
  output logic [IDX_W-1:0]   char_idx,
  output logic               show_en,
  output logic               prompt,
  output logic               correct,
  output logic               wrong,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               done
);
  state_t r_state, w_nxt;
  logic w_exp, w_match, w_last, w_clr, w_start, w_fb_hold;
  logic w_correct, w_wrong;
  logic [3:0] w_limit;
  logic [IDX_W-1:0] w_idx;
  logic [SCORE_W-1:0] w_score;
  assign w_match = dots_in == char_pattern;
  assign w_last  = char_idx == IDX_W'(NUM_CHARS - 1);
  assign w_limit = r_state == ST_SHOW   ? 4'(SHOW_SECS)
                 : r_state == ST_ANSWER ? 4'(ANSWER_SECS) : 4'(FB_SECS);
  // Any state change restarts the dwell count so each state sees a fresh count of 0.
  assign w_clr = w_nxt != r_state;
  sec_dwell_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (w_clr),
    .timeout1s(timeout1s),
    .limit    (w_limit),
    .expire   (w_exp)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state  <= ST_IDLE;
      char_idx <= '0;
      score    <= '0;
      show_en  <= 1'b0;
      prompt   <= 1'b0;
      correct  <= 1'b0;
      wrong    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      char_idx <= w_idx;
      score    <= w_score;
      show_en  <= w_nxt == ST_SHOW;
      prompt   <= w_nxt == ST_ANSWER;
      correct  <= w_correct;
      wrong    <= w_wrong;
      busy     <= w_nxt != ST_IDLE && w_nxt != ST_DONE;
      done     <= w_nxt == ST_DONE;
    end
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: w_nxt = start ? ST_SHOW : r_state;
      ST_SHOW:          w_nxt = w_exp ? ST_ANSWER : ST_SHOW;
      ST_ANSWER:        w_nxt = (submit || w_exp) ? ST_FEEDBACK : ST_ANSWER;
      ST_FEEDBACK:      w_nxt = !w_exp ? ST_FEEDBACK : w_last ? ST_DONE : ST_SHOW;
      default:          w_nxt = ST_IDLE;
    endcase
  end
  // Submit takes priority over an expiring tick in the same cycle.
  always_comb begin
    w_start   = (r_state == ST_IDLE || r_state == ST_DONE) && start;
    w_fb_hold = r_state == ST_FEEDBACK && w_nxt == ST_FEEDBACK;
    w_correct = r_state == ST_ANSWER ? submit && w_match : w_fb_hold && correct;
    w_wrong   = r_state == ST_ANSWER ? (submit ? !w_match : w_exp) : w_fb_hold && wrong;
    w_idx     = w_start ? '0
              : (r_state == ST_FEEDBACK && w_exp && !w_last) ? char_idx + IDX_W'(1) : char_idx;
    w_score   = w_start ? '0
              : (r_state == ST_ANSWER && submit && w_match && score != '1) ? score + SCORE_W'(1) : score;
  end
endmodule

// File: tb/tb_braille_session_ctrl.sv
// tb_braille_session_ctrl: directed session walk-through with hand-computed expected outputs.
module tb_braille_session_ctrl;
  logic clk = 1'b0, rst = 1'b1, timeout1s = 1'b0, start = 1'b0, submit = 1'b0;
  logic [5:0] dots_in = '0, char_pattern;
  logic [4:0] char_idx;
  logic [1:0] score;
  logic show_en, prompt, correct, wrong, busy, done;
  int n_tot = 0, n_bad = 0;
  always #5 clk = ~clk;
  // ROM model: pattern of character i is i+1.
  assign char_pattern = 6'(char_idx) + 6'd1;
  braille_session_ctrl #(.NUM_CHARS(5), .SCORE_W(2)) dut (
    .clk(clk), .rst(rst), .timeout1s(timeout1s), .start(start), .submit(submit),
    .dots_in(dots_in), .char_pattern(char_pattern), .char_idx(char_idx),
    .show_en(show_en), .prompt(prompt), .correct(correct), .wrong(wrong),
    .score(score), .busy(busy), .done(done)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic st(input string tag, input int idx, input int sc, input int sh, input int pr,
                    input int co, input int wr, input int bu, input int dn);
    chk({tag, ".idx"}, 32'(char_idx), idx);
    chk({tag, ".score"}, 32'(score), sc);
    chk({tag, ".show"}, 32'(show_en), sh);
    chk({tag, ".prompt"}, 32'(prompt), pr);
    chk({tag, ".correct"}, 32'(correct), co);
    chk({tag, ".wrong"}, 32'(wrong), wr);
    chk({tag, ".busy"}, 32'(busy), bu);
    chk({tag, ".done"}, 32'(done), dn);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic tick(input logic sub, input logic [5:0] d);
    repeat (9) step();
    timeout1s = 1'b1;
    submit = sub;
    dots_in = d;
    step();
    timeout1s = 1'b0;
    submit = 1'b0;
  endtask
  task automatic answer(input logic [5:0] d);
    dots_in = d;
    submit = 1'b1;
    step();
    submit = 1'b0;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  initial begin
    #12;
    st("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    step();
    st("idle", 0, 0, 0, 0, 0, 0, 0, 0);
    pulse_start();
    st("start", 0, 0, 1, 0, 0, 0, 1, 0);
    tick(0, 0);
    st("show_t1", 0, 0, 1, 0, 0, 0, 1, 0);
    tick(0, 0);
    st("answer0", 0, 0, 0, 1, 0, 0, 1, 0);
    answer(6'd1);
    st("ok_fb", 0, 1, 0, 0, 1, 0, 1, 0);
    tick(0, 0);
    st("adv1", 1, 1, 1, 0, 0, 0, 1, 0);
    tick(0, 0);
    tick(0, 0);
    repeat (4) tick(0, 0);
    st("ans_t4", 1, 1, 0, 1, 0, 0, 1, 0);
    tick(0, 0);
    st("timeout", 1, 1, 0, 0, 0, 1, 1, 0);
    pulse_start();
    st("start_busy", 1, 1, 0, 0, 0, 1, 1, 0);
    answer(6'd2);
    st("sub_fb", 1, 1, 0, 0, 0, 1, 1, 0);
    tick(0, 0);
    st("adv2", 2, 1, 1, 0, 0, 0, 1, 0);
    answer(6'd3);
    st("sub_show", 2, 1, 1, 0, 0, 0, 1, 0);
    tick(0, 0);
    tick(0, 0);
    repeat (4) tick(0, 0);
    tick(1, 6'd3);
    st("coincide", 2, 2, 0, 0, 1, 0, 1, 0);
    tick(0, 0);
    tick(0, 0);
    tick(0, 0);
    answer(6'd4);
    st("score3", 3, 3, 0, 0, 1, 0, 1, 0);
    tick(0, 0);
    tick(0, 0);
    tick(0, 0);
    answer(6'd5);
    st("saturate", 4, 3, 0, 0, 1, 0, 1, 0);
    tick(0, 0);
    st("done", 4, 3, 0, 0, 0, 0, 0, 1);
    tick(1, 6'd5);
    st("done_hold", 4, 3, 0, 0, 0, 0, 0, 1);
    pulse_start();
    st("restart", 0, 0, 1, 0, 0, 0, 1, 0);
    tick(0, 0);
    tick(0, 0);
    answer(6'd1);
    tick(0, 0);
    tick(0, 0);
    tick(0, 0);
    answer(6'd2);
    tick(0, 0);
    tick(0, 0);
    tick(0, 0);
    st("pre_rst", 2, 2, 0, 1, 0, 0, 1, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 st("async_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    step();
    pulse_start();
    st("fresh", 0, 0, 1, 0, 0, 0, 1, 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
